sync_fifo_flex: RTL and testbench

//  Single-clock parametrised FIFO; next generation of our dual-clock FIFO for same-domain buffering.

---
 rtl/sync_fifo_flex_if.sv | 30 +++
 rtl/sync_fifo_flex.sv | 93 +++++++++
 tb/tb_sync_fifo_flex.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flex_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_flex.
interface sync_fifo_flex_if #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned ADDR_SIZE  = 9
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_SIZE:0]    count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost flags and a selectable
// standard (registered) or first-word-fall-through read port.
module sync_fifo_flex #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned ADDR_SIZE  = 9,
    parameter int unsigned AF_THRESH  = 508,
    parameter int unsigned AE_THRESH  = 4,
    parameter bit          FWFT       = 1'b0
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_flex_if.slave f
);
    localparam int unsigned FIFO_DEPTH = 2 ** ADDR_SIZE;
    localparam int unsigned CW         = ADDR_SIZE + 1;
    localparam logic [CW-1:0] DEPTH_LVL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_LVL    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL    = CW'(AE_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]         wr_ptr;
    logic [CW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_c;
    logic                  empty_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // Accept decisions use the flags as seen at the edge; no bypass.
    assign full_c   = (count_q == DEPTH_LVL);
    assign empty_c  = (count_q == '0);
    assign wr_acc_c = f.wr_en && !full_c;
    assign rd_acc_c = f.rd_en && !empty_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc_c) wr_ptr <= wr_ptr + CW'(1);
            if (rd_acc_c) rd_ptr <= rd_ptr + CW'(1);
            case ({wr_acc_c, rd_acc_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            overflow_q  <= f.wr_en && full_c;
            underflow_q <= f.rd_en && empty_c;
        end
    end

    // Storage is never cleared; reset only discards it via the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_c) mem[wr_ptr[ADDR_SIZE-1:0]] <= f.data_in;
    end

    generate
        if (FWFT == 1'b0) begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc_c;
                    if (rd_acc_c) dout_q <= mem[rd_ptr[ADDR_SIZE-1:0]];
                end
            end

            assign f.data_out = dout_q;
            assign f.valid    = valid_q;
        end else begin : g_fwft
            // Head word is presented directly; forced to zero while empty.
            assign f.data_out = empty_c ? '0 : mem[rd_ptr[ADDR_SIZE-1:0]];
            assign f.valid    = !empty_c;
        end
    endgenerate

    assign f.full         = full_c;
    assign f.empty        = empty_c;
    assign f.almost_full  = (count_q >= AF_LVL);
    assign f.almost_empty = (count_q <= AE_LVL);
    assign f.count        = count_q;
    assign f.overflow     = overflow_q;
    assign f.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed and scoreboarded checks of sync_fifo_flex in both read modes.
module tb_sync_fifo_flex;
    localparam int unsigned W  = 16;
    localparam int unsigned A  = 9;
    localparam int unsigned D  = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.FIFO_WIDTH(W), .ADDR_SIZE(A)) f0 ();
    sync_fifo_flex_if #(.FIFO_WIDTH(W), .ADDR_SIZE(A)) f1 ();

    sync_fifo_flex #(.FIFO_WIDTH(W), .ADDR_SIZE(A), .AF_THRESH(508), .AE_THRESH(4), .FWFT(1'b0))
        u_std (.clk(clk), .rst(rst), .f(f0));
    sync_fifo_flex #(.FIFO_WIDTH(W), .ADDR_SIZE(A), .AF_THRESH(508), .AE_THRESH(4), .FWFT(1'b1))
        u_fwft (.clk(clk), .rst(rst), .f(f1));

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [9:0]  cnt;
        logic        emp;
        logic        ful;
        logic        vld;
        logic [15:0] dout;
        logic        ovf;
        logic        udf;
        logic        ae;
        logic        af;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic wr, input logic rd, input logic [15:0] din);
        f0.wr_en   = wr;
        f0.rd_en   = rd;
        f0.data_in = din;
    endtask

    logic [15:0] q[$];
    logic [15:0] exp_w;
    int          nwr;
    int          cyc;
    logic        wr_r, rd_r, wacc, racc;

    initial begin
        drive0(1'b1, 1'b1, 16'h0);
        f1.wr_en = 1'b0; f1.rd_en = 1'b0; f1.data_in = '0;

        //            rst wr rd din      cnt emp ful vld dout     ovf udf ae af
        vecs[0] = '{1, 1, 1, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0};
        vecs[1] = '{1, 1, 1, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 0};
        vecs[2] = '{0, 1, 1, 16'h1111, 1, 0, 0, 0, 16'h0000, 0, 1, 1, 0};
        vecs[3] = '{0, 1, 0, 16'h2222, 2, 0, 0, 0, 16'h0000, 0, 0, 1, 0};
        vecs[4] = '{0, 1, 1, 16'h3333, 2, 0, 0, 1, 16'h1111, 0, 0, 1, 0};
        vecs[5] = '{0, 0, 1, 16'h0000, 1, 0, 0, 1, 16'h2222, 0, 0, 1, 0};
        vecs[6] = '{0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h2222, 0, 0, 1, 0};
        vecs[7] = '{0, 0, 1, 16'h0000, 0, 1, 0, 1, 16'h3333, 0, 0, 1, 0};
        vecs[8] = '{0, 0, 1, 16'h0000, 0, 1, 0, 0, 16'h3333, 0, 1, 1, 0};
        vecs[9] = '{0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h3333, 0, 0, 1, 0};

        // Reset with requests pending, then simultaneous/underflow cases
        for (int i = 0; i < 10; i++) begin
            rst = vecs[i].rst;
            drive0(vecs[i].wr, vecs[i].rd, vecs[i].din);
            tick();
            chk($sformatf("vec%0d", i),
                64'({f0.count, f0.empty, f0.full, f0.valid, f0.data_out,
                     f0.overflow, f0.underflow, f0.almost_empty, f0.almost_full}),
                64'({vecs[i].cnt, vecs[i].emp, vecs[i].ful, vecs[i].vld, vecs[i].dout,
                     vecs[i].ovf, vecs[i].udf, vecs[i].ae, vecs[i].af}));
        end

        // Fill to full and watch the thresholds
        for (int i = 0; i < int'(D); i++) begin
            drive0(1'b1, 1'b0, 16'(i));
            tick();
            chk("fill_cnt", 64'(f0.count), 64'(i + 1));
            chk("fill_af", 64'(f0.almost_full), 64'((i + 1) >= 508));
            chk("fill_full", 64'(f0.full), 64'((i + 1) == int'(D)));
            chk("fill_ae", 64'(f0.almost_empty), 64'((i + 1) <= 4));
        end
        drive0(1'b1, 1'b0, 16'hFFFF);
        tick();
        chk("ovf_pulse", 64'({f0.overflow, f0.count}), 64'({1'b1, 10'd512}));
        drive0(1'b0, 1'b0, 16'h0);
        tick();
        chk("ovf_clear", 64'({f0.overflow, f0.count}), 64'({1'b0, 10'd512}));

        // Drain in order, one cycle read latency
        for (int i = 0; i < int'(D); i++) begin
            drive0(1'b0, 1'b1, 16'h0);
            tick();
            chk("drain_data", 64'({f0.valid, f0.data_out}), 64'({1'b1, 16'(i)}));
            chk("drain_cnt", 64'(f0.count), 64'(int'(D) - 1 - i));
            chk("drain_ae", 64'(f0.almost_empty), 64'((int'(D) - 1 - i) <= 4));
            chk("drain_empty", 64'(f0.empty), 64'(i == int'(D) - 1));
        end
        tick();
        chk("udf_pulse", 64'({f0.underflow, f0.valid, f0.count}), 64'({1'b1, 1'b0, 10'd0}));

        // Refill, then read+write while full
        for (int i = 0; i < int'(D); i++) begin
            drive0(1'b1, 1'b0, 16'h1000 + 16'(i));
            tick();
        end
        chk("refill_full", 64'({f0.full, f0.count}), 64'({1'b1, 10'd512}));
        drive0(1'b1, 1'b1, 16'hDEAD);
        tick();
        chk("full_both", 64'({f0.count, f0.overflow, f0.valid, f0.data_out}),
            64'({10'd511, 1'b1, 1'b1, 16'h1000}));
        for (int i = 1; i < 256; i++) begin
            drive0(1'b0, 1'b1, 16'h0);
            tick();
            chk("mid_read", 64'(f0.data_out), 64'(16'h1000 + 16'(i)));
        end
        drive0(1'b1, 1'b1, 16'h7777);
        tick();
        chk("mid_both", 64'({f0.count, f0.data_out}), 64'({10'd256, 16'h1100}));
        for (int i = 0; i < 256; i++) begin
            drive0(1'b0, 1'b1, 16'h0);
            tick();
            exp_w = (i == 255) ? 16'h7777 : 16'h1101 + 16'(i);
            chk("mid_order", 64'(f0.data_out), 64'(exp_w));
        end
        drive0(1'b0, 1'b0, 16'h0);
        tick();
        chk("mid_empty", 64'({f0.empty, f0.count}), 64'({1'b1, 10'd0}));

        // First-word-fall-through port
        chk("fwft_idle", 64'({f1.valid, f1.empty}), 64'({1'b0, 1'b1}));
        f1.wr_en = 1'b1; f1.data_in = 16'hA5A5;
        tick();
        f1.wr_en = 1'b0;
        chk("fwft_show", 64'({f1.valid, f1.data_out}), 64'({1'b1, 16'hA5A5}));
        tick();
        chk("fwft_hold", 64'({f1.valid, f1.data_out}), 64'({1'b1, 16'hA5A5}));
        f1.rd_en = 1'b1;
        tick();
        f1.rd_en = 1'b0;
        chk("fwft_pop", 64'({f1.valid, f1.empty}), 64'({1'b0, 1'b1}));
        f1.wr_en = 1'b1; f1.data_in = 16'h0001;
        tick();
        f1.data_in = 16'h0002;
        tick();
        f1.wr_en = 1'b0;
        chk("fwft_head", 64'({f1.count, f1.data_out}), 64'({10'd2, 16'h0001}));
        f1.rd_en = 1'b1;
        tick();
        chk("fwft_next", 64'({f1.valid, f1.data_out}), 64'({1'b1, 16'h0002}));
        tick();
        f1.rd_en = 1'b0;
        chk("fwft_done", 64'({f1.valid, f1.empty}), 64'({1'b0, 1'b1}));

        // Random stream across pointer wrap against a queue model
        rst = 1'b1;
        drive0(1'b0, 1'b0, 16'h0);
        tick();
        rst = 1'b0;
        q.delete();
        nwr = 0;
        cyc = 0;
        while ((nwr < 1500 || q.size() != 0) && cyc < 20000) begin
            wr_r = (nwr < 1500) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd_r = (nwr < 1500) ? 1'($urandom_range(0, 1)) : 1'b1;
            drive0(wr_r, rd_r, 16'(nwr * 7 + 3));
            wacc = wr_r && (q.size() != int'(D));
            racc = rd_r && (q.size() != 0);
            tick();
            if (racc) begin
                exp_w = q.pop_front();
                chk("rnd_data", 64'({f0.valid, f0.data_out}), 64'({1'b1, exp_w}));
            end
            if (wacc) begin
                q.push_back(16'(nwr * 7 + 3));
                nwr++;
            end
            chk("rnd_cnt", 64'(f0.count), 64'(q.size()));
            cyc++;
        end
        chk("rnd_budget", 64'(cyc < 20000), 64'(1));

        // Mid-stream reset discards content
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 1'b0, 16'h4000 + 16'(i));
            tick();
        end
        rst = 1'b1;
        drive0(1'b1, 1'b1, 16'h5555);
        tick();
        rst = 1'b0;
        chk("rst_mid", 64'({f0.count, f0.empty, f0.valid, f0.overflow, f0.underflow}),
            64'({10'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        drive0(1'b1, 1'b0, 16'hBEEF);
        tick();
        drive0(1'b0, 1'b1, 16'h0);
        tick();
        chk("rst_first", 64'({f0.valid, f0.data_out, f0.count}), 64'({1'b1, 16'hBEEF, 10'd0}));
        drive0(1'b0, 1'b0, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
